pipe_trace_buffer: RTL

Synthesizable successor to the MIPS pipeline cycle monitor: captures a parametrised number of pipeline-register channels plus a free-running cycle stamp into a circular trace buffer on every valid cycle, with arm/trigger/post-trigger control. Sits beside the `MIPS` core; channel inputs tap stage-boundary signals (IF/ID, ID/EX, EX/MEM, MEM/WB). A host or bench reads the frozen trace afterwards through a random-access read port.

---
 rtl/trace_pkg.sv | 16 +
 rtl/trace_ram.sv | 27 ++
 rtl/pipe_trace_buffer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared types for the pipeline trace buffer:
// capture state encoding and capture-mode constants.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_CONT = 2'b00;
  localparam logic [1:0] MODE_TRIG = 2'b01;
  localparam logic [1:0] MODE_SHOT = 2'b10;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: one write port, one registered read port.
// A same-edge write to the read address is forwarded.
module trace_ram #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= (we_i && waddr_i == raddr_i)
             ? wdata_i : mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pipe_trace_buffer.sv
// Circular trace of pipeline channels plus cycle stamp,
// with arm / trigger / post-trigger capture control.
module pipe_trace_buffer
  import trace_pkg::*;
#(
  parameter  int CHANNELS  = 5,
  parameter  int CH_WIDTH  = 32,
  parameter  int DEPTH     = 16,
  parameter  int CNT_WIDTH = 32,
  localparam int AW        = $clog2(DEPTH),
  localparam int DW        = CHANNELS * CH_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DW-1:0]        ch_data,
  input  logic                 arm,
  input  logic                 trig,
  input  logic [1:0]           mode,
  input  logic [AW-1:0]        post_count,
  input  logic [AW-1:0]        rd_addr,
  output logic [DW-1:0]        rd_data,
  output logic [CNT_WIDTH-1:0] rd_stamp,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [AW:0]          fill,
  output logic [AW-1:0]        trig_index,
  output logic                 triggered,
  output logic                 busy,
  output logic                 done
);

  localparam int          EW   = DW + CNT_WIDTH;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]          fill_q, fill_d;
  logic [AW-1:0]        trig_ptr_q, trig_ptr_d;
  logic                 trg_q, trg_d;
  logic [AW-1:0]        rem_q, rem_d;
  logic [1:0]           mode_q, mode_d;
  logic                 rd_ok_q;
  logic                 cap;
  logic [AW-1:0]        rd_phys;
  logic [EW-1:0]        ram_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      trig_ptr_q <= '0;
      trg_q      <= 1'b0;
      rem_q      <= '0;
      mode_q     <= MODE_CONT;
      rd_ok_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_q + 1'b1;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      trig_ptr_q <= trig_ptr_d;
      trg_q      <= trg_d;
      rem_q      <= rem_d;
      mode_q     <= mode_d;
      rd_ok_q    <= {1'b0, rd_addr} < fill_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    trig_ptr_d = trig_ptr_q;
    trg_d      = trg_q;
    rem_d      = rem_q;
    mode_d     = mode_q;
    cap        = 1'b0;
    if (arm) begin
      state_d  = ARMED;
      wr_ptr_d = '0;
      fill_d   = '0;
      trg_d    = 1'b0;
      mode_d   = mode;
    end else if (in_valid &&
                 (state_q == ARMED || state_q == POST)) begin
      cap      = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (fill_q != FULL) fill_d = fill_q + 1'b1;
      unique case (1'b1)
        state_q == POST: begin
          rem_d = rem_q - 1'b1;
          if (rem_q == AW'(1)) state_d = DONE;
        end
        mode_q == MODE_CONT: begin
          if (trig && !trg_q) begin
            trg_d      = 1'b1;
            trig_ptr_d = wr_ptr_q;
          end
        end
        mode_q == MODE_SHOT: begin
          if (fill_q == FULL - 1'b1) state_d = DONE;
        end
        default: begin
          // Reserved mode 11 falls here and acts as trigger-stop.
          if (trig) begin
            trg_d      = 1'b1;
            trig_ptr_d = wr_ptr_q;
            rem_d      = post_count;
            state_d    = (post_count == '0) ? DONE : POST;
          end
        end
      endcase
    end
  end

  // Address from post-edge pointers so data shows the new state.
  assign rd_phys = wr_ptr_d - fill_d[AW-1:0] + rd_addr;

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk     (clk),
    .we_i    (cap),
    .waddr_i (wr_ptr_q),
    .wdata_i ({ch_data, cnt_q}),
    .raddr_i (rd_phys),
    .rdata_o (ram_rd)
  );

  always_comb begin
    busy        = (state_q == ARMED) || (state_q == POST);
    done        = (state_q == DONE);
    triggered   = trg_q;
    fill        = fill_q;
    cycle_count = cnt_q;
    trig_index  = trg_q
                ? trig_ptr_q - (wr_ptr_q - fill_q[AW-1:0])
                : '0;
    rd_data     = rd_ok_q ? ram_rd[EW-1:CNT_WIDTH] : '0;
    rd_stamp    = rd_ok_q ? ram_rd[CNT_WIDTH-1:0] : '0;
  end

endmodule
